pipe_control_unit: RTL and testbench
====================================

Name: pipe_control_unit

Overview:
- Parametrised, pipelined successor to the single-cycle MIPS control decoder for the five-stage pipeline.
- Decodes the ID-stage opcode into an EX/MEM/WB control bundle and carries it through ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards and generates stall signals; applies jump and branch flushes.
- Illegal opcodes become bubbles, never X.

Parameters:
- OPCODE_W, 6, opcode field width.
- REG_W, 5, register-specifier width.
- ALUOP_W, 2, ALUOp width to ALU control.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- id_opcode  in  OPCODE_W  opcode of the instruction in ID.
- id_rs  in  REG_W  rs field in ID.
- id_rt  in  REG_W  rt field in ID.
- branch_taken  in  1  from MEM: (mem_branch & zero) | (mem_bne & ~zero).
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  clear IF/ID.
- id_jump  out  1  jump decoded in ID; selects the jump target for the PC.
- ex_reg_dst, ex_alu_src, ex_ori  out  1 each  EX control (registered).
- ex_alu_op  out  ALUOP_W  registered ALUOp.
- mem_read, mem_write, mem_branch, mem_bne  out  1 each  MEM control (registered).
- wb_reg_write, wb_mem_to_reg  out  1 each  WB control (registered).
- illegal_op  out  1  one-cycle pulse when an illegal opcode is decoded in ID and not stalled or flushed.

Behaviour:
- Decode table (combinational in ID):
  - R=0: RegDst=1, ALUOp=10, RegWrite=1.
  - ADDI=8: ALUSrc=1, ALUOp=00, RegWrite=1.
  - ORI=13: ALUSrc=1, ori=1, ALUOp=11, RegWrite=1.
  - LW=35: ALUSrc=1, ALUOp=00, MemRead=1, MemtoReg=1, RegWrite=1.
  - SW=43: ALUSrc=1, ALUOp=00, MemWrite=1.
  - BEQ=4: Branch=1, ALUOp=01.
  - BNE=5: bne=1, ALUOp=01.
  - J=2: id_jump=1, all bundle bits 0.
  - All unlisted bits are 0. No X is ever driven.
- Register usage for hazard checks: reads_rt=1 only for R, SW, BEQ and BNE. reads_rs=1 for every opcode except J.
- Pipelining: the bundle is captured into ID/EX, then EX/MEM, then MEM/WB, one stage per clk. EX outputs lag ID by 1 cycle, MEM by 2, WB by 3.
- ID/EX also holds ex_rt_q and ex_mem_read_q for hazard detection.
- Load-use hazard (combinational):
  - hazard = ex_mem_read_q & (ex_rt_q != 0) & ((reads_rs & id_rs == ex_rt_q) | (reads_rt & id_rt == ex_rt_q)).
  - On hazard: pc_write=0, ifid_write=0, and ID/EX loads an all-zero bubble. EX/MEM and MEM/WB advance normally.
  - Exactly one stall cycle per load-use pair.
- Jump: id_jump=1 with no flush asserts ifid_flush for that cycle. The ID/EX bubble is J's own all-zero bundle.
  - If a hazard occurs in the same cycle, the hazard wins and the jump repeats next cycle. This cannot occur in practice, since J does not read rs or rt.
- Branch: branch_taken=1 forces the following in the same cycle:
  - ifid_flush=1;
  - ID/EX and EX/MEM load zero bundles;
  - MEM/WB loads normally (the branch itself writes nothing).
  - pc_write=1 and ifid_write=1, overriding any hazard stall.
- Priority: rst > branch_taken > hazard > jump.
- Illegal opcode: loads a zero bundle and pulses illegal_op. Suppressed while hazard or branch_taken is asserted.
- Reset: all stage registers 0, so every registered output is 0. Combinational outputs settle to pc_write=1, ifid_write=1, ifid_flush=0, illegal_op=0.
  - Reset asserted mid-stream discards all in-flight bundles on the same edge.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- When defined:
  - Adds outputs trap_flag (1) and trap_opcode (OPCODE_W).
  - The first illegal_op pulse sets trap_flag and captures the opcode.
  - The flag is sticky until rst; later illegal opcodes do not overwrite the captured value.
- When undefined: no trap ports; illegal opcodes behave as a NOP bubble plus the illegal_op pulse only.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - opcode constants;
  - ALUOp encodings (00 add, 01 sub, 10 funct, 11 or);
  - packed struct types ex_ctrl_t, mem_ctrl_t, wb_ctrl_t;
  - zero-bundle constants.
- One sub-module, ctrl_decode: purely combinational opcode-to-bundle decode plus reads_rs/reads_rt. The top level holds the stage registers and hazard/flush logic.

Test Plan:
- Reset, then R-type (opcode 0) in ID at cycle 0 -> ex_reg_dst=1 and ex_alu_op=10 at cycle 1; wb_reg_write=1 at cycle 3; all outputs 0 during rst.
- LW rt=5 in ID, next instruction R-type with rs=5 -> pc_write=0 and ifid_write=0 for exactly 1 cycle; the ex_* bundle is 0 in the following cycle; the R-type reaches EX one cycle late.
- LW rt=5 followed by ADDI rt=5, rs=3 -> no stall (rt not read); LW rt=0 followed by a use of $0 -> no stall.
- BEQ with branch_taken=1 at its MEM cycle, while a load-use hazard is also present -> ifid_flush=1, pc_write=1, and EX/MEM bundles are 0 next cycle.
- J (opcode 2) -> id_jump=1 and ifid_flush=1 in the same cycle; the J bundle is all-zero through WB.
- Opcode 63 twice, then rst -> illegal_op pulses once per instance. With ILLEGAL_TRAP_EN: trap_flag=1 and trap_opcode=63 hold until rst, then clear to 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode constants, ALUOp encodings and the per-stage control bundle
// types of the pipelined MIPS control unit.
package pipe_ctrl_pkg;

    localparam int OPC_BITS   = 6;
    localparam int ALUOP_BITS = 2;

    localparam logic [OPC_BITS-1:0] OP_R    = 6'd0;
    localparam logic [OPC_BITS-1:0] OP_J    = 6'd2;
    localparam logic [OPC_BITS-1:0] OP_BEQ  = 6'd4;
    localparam logic [OPC_BITS-1:0] OP_BNE  = 6'd5;
    localparam logic [OPC_BITS-1:0] OP_ADDI = 6'd8;
    localparam logic [OPC_BITS-1:0] OP_ORI  = 6'd13;
    localparam logic [OPC_BITS-1:0] OP_LW   = 6'd35;
    localparam logic [OPC_BITS-1:0] OP_SW   = 6'd43;

    localparam logic [ALUOP_BITS-1:0] ALU_ADD   = 2'b00;
    localparam logic [ALUOP_BITS-1:0] ALU_SUB   = 2'b01;
    localparam logic [ALUOP_BITS-1:0] ALU_FUNCT = 2'b10;
    localparam logic [ALUOP_BITS-1:0] ALU_OR    = 2'b11;

    typedef struct packed {
        logic                  reg_dst;
        logic                  alu_src;
        logic                  ori;
        logic [ALUOP_BITS-1:0] alu_op;
    } ex_ctrl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic branch;
        logic bne;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    localparam ex_ctrl_t  EX_ZERO  = '0;
    localparam mem_ctrl_t MEM_ZERO = '0;
    localparam wb_ctrl_t  WB_ZERO  = '0;

endpackage

// File: rtl/pipe_control_unit_ctrl_decode.sv
// Purely combinational ID-stage decode: opcode to EX/MEM/WB bundle, jump and
// illegal flags, and which source registers the instruction reads.
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] i_opcode,
    output ex_ctrl_t            o_ex,
    output mem_ctrl_t           o_mem,
    output wb_ctrl_t            o_wb,
    output logic                o_jump,
    output logic                o_illegal,
    output logic                o_reads_rs,
    output logic                o_reads_rt
);

    always_comb begin
        o_ex       = EX_ZERO;
        o_mem      = MEM_ZERO;
        o_wb       = WB_ZERO;
        o_jump     = 1'b0;
        o_illegal  = 1'b0;
        o_reads_rt = 1'b0;
        case (i_opcode)
            OPCODE_W'(OP_R): begin
                o_ex.reg_dst    = 1'b1;
                o_ex.alu_op     = ALU_FUNCT;
                o_wb.reg_write  = 1'b1;
                o_reads_rt      = 1'b1;
            end
            OPCODE_W'(OP_ADDI): begin
                o_ex.alu_src    = 1'b1;
                o_ex.alu_op     = ALU_ADD;
                o_wb.reg_write  = 1'b1;
            end
            OPCODE_W'(OP_ORI): begin
                o_ex.alu_src    = 1'b1;
                o_ex.ori        = 1'b1;
                o_ex.alu_op     = ALU_OR;
                o_wb.reg_write  = 1'b1;
            end
            OPCODE_W'(OP_LW): begin
                o_ex.alu_src    = 1'b1;
                o_ex.alu_op     = ALU_ADD;
                o_mem.mem_read  = 1'b1;
                o_wb.mem_to_reg = 1'b1;
                o_wb.reg_write  = 1'b1;
            end
            OPCODE_W'(OP_SW): begin
                o_ex.alu_src    = 1'b1;
                o_ex.alu_op     = ALU_ADD;
                o_mem.mem_write = 1'b1;
                o_reads_rt      = 1'b1;
            end
            OPCODE_W'(OP_BEQ): begin
                o_mem.branch    = 1'b1;
                o_ex.alu_op     = ALU_SUB;
                o_reads_rt      = 1'b1;
            end
            OPCODE_W'(OP_BNE): begin
                o_mem.bne       = 1'b1;
                o_ex.alu_op     = ALU_SUB;
                o_reads_rt      = 1'b1;
            end
            OPCODE_W'(OP_J): begin
                o_jump          = 1'b1;
            end
            default: begin
                o_illegal       = 1'b1;
            end
        endcase
        // Every instruction except J reads rs, illegal ones included.
        o_reads_rs = ~o_jump;
    end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined MIPS control unit: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use stall and jump/branch flush. Optional sticky trap via ILLEGAL_TRAP_EN.
module pipe_control_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int REG_W    = 5,
    parameter int ALUOP_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] id_opcode,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic                branch_taken,
    output logic                pc_write,
    output logic                ifid_write,
    output logic                ifid_flush,
    output logic                id_jump,
    output logic                ex_reg_dst,
    output logic                ex_alu_src,
    output logic                ex_ori,
    output logic [ALUOP_W-1:0]  ex_alu_op,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_branch,
    output logic                mem_bne,
    output logic                wb_reg_write,
    output logic                wb_mem_to_reg,
    output logic                illegal_op
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic                trap_flag,
    output logic [OPCODE_W-1:0] trap_opcode
`endif
);

    ex_ctrl_t   w_dec_ex;
    mem_ctrl_t  w_dec_mem;
    wb_ctrl_t   w_dec_wb;
    logic       w_jump;
    logic       w_illegal;
    logic       w_reads_rs;
    logic       w_reads_rt;
    logic       w_hazard;
    logic       w_bubble;

    ex_ctrl_t   r_idex_ex;
    mem_ctrl_t  r_idex_mem;
    wb_ctrl_t   r_idex_wb;
    logic [REG_W-1:0] r_idex_rt;
    mem_ctrl_t  r_exmem_mem;
    wb_ctrl_t   r_exmem_wb;
    wb_ctrl_t   r_memwb_wb;

    ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .i_opcode   (id_opcode),
        .o_ex       (w_dec_ex),
        .o_mem      (w_dec_mem),
        .o_wb       (w_dec_wb),
        .o_jump     (w_jump),
        .o_illegal  (w_illegal),
        .o_reads_rs (w_reads_rs),
        .o_reads_rt (w_reads_rt)
    );

    assign w_hazard = r_idex_mem.mem_read && (r_idex_rt != '0) &&
                      ((w_reads_rs && (id_rs == r_idex_rt)) ||
                       (w_reads_rt && (id_rt == r_idex_rt)));
    assign w_bubble = branch_taken || w_hazard;

    // A taken branch overrides the stall; reset masks every ID-side strobe.
    assign pc_write   = rst || branch_taken || !w_hazard;
    assign ifid_write = pc_write;
    assign ifid_flush = !rst && (branch_taken || (w_jump && !w_hazard));
    assign id_jump    = !rst && w_jump;
    assign illegal_op = !rst && w_illegal && !w_bubble;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idex_ex   <= EX_ZERO;
            r_idex_mem  <= MEM_ZERO;
            r_idex_wb   <= WB_ZERO;
            r_idex_rt   <= '0;
            r_exmem_mem <= MEM_ZERO;
            r_exmem_wb  <= WB_ZERO;
            r_memwb_wb  <= WB_ZERO;
        end else begin
            if (w_bubble) begin
                r_idex_ex  <= EX_ZERO;
                r_idex_mem <= MEM_ZERO;
                r_idex_wb  <= WB_ZERO;
                r_idex_rt  <= '0;
            end else begin
                r_idex_ex  <= w_dec_ex;
                r_idex_mem <= w_dec_mem;
                r_idex_wb  <= w_dec_wb;
                r_idex_rt  <= id_rt;
            end
            if (branch_taken) begin
                r_exmem_mem <= MEM_ZERO;
                r_exmem_wb  <= WB_ZERO;
            end else begin
                r_exmem_mem <= r_idex_mem;
                r_exmem_wb  <= r_idex_wb;
            end
            r_memwb_wb <= r_exmem_wb;
        end
    end

    assign ex_reg_dst    = r_idex_ex.reg_dst;
    assign ex_alu_src    = r_idex_ex.alu_src;
    assign ex_ori        = r_idex_ex.ori;
    assign ex_alu_op     = ALUOP_W'(r_idex_ex.alu_op);
    assign mem_read      = r_exmem_mem.mem_read;
    assign mem_write     = r_exmem_mem.mem_write;
    assign mem_branch    = r_exmem_mem.branch;
    assign mem_bne       = r_exmem_mem.bne;
    assign wb_reg_write  = r_memwb_wb.reg_write;
    assign wb_mem_to_reg = r_memwb_wb.mem_to_reg;

`ifdef ILLEGAL_TRAP_EN
    logic                r_trap_flag;
    logic [OPCODE_W-1:0] r_trap_opcode;

    // First reported illegal opcode wins; the flag stays until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trap_flag   <= 1'b0;
            r_trap_opcode <= '0;
        end else if (illegal_op && !r_trap_flag) begin
            r_trap_flag   <= 1'b1;
            r_trap_opcode <= id_opcode;
        end
    end

    assign trap_flag   = r_trap_flag;
    assign trap_opcode = r_trap_opcode;
`endif

endmodule

// File: tb/tb_pipe_control_unit.sv
// Scoreboard bench for pipe_control_unit: expected stage bundles are queued as
// instructions are issued and compared as they emerge in EX, MEM and WB.
module tb_pipe_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] id_opcode;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       branch_taken;
    logic       pc_write, ifid_write, ifid_flush, id_jump;
    logic       ex_reg_dst, ex_alu_src, ex_ori;
    logic [1:0] ex_alu_op;
    logic       mem_read, mem_write, mem_branch, mem_bne;
    logic       wb_reg_write, wb_mem_to_reg;
    logic       illegal_op;
`ifdef ILLEGAL_TRAP_EN
    logic       trap_flag;
    logic [5:0] trap_opcode;
`endif

    always #5 clk = ~clk;

    pipe_control_unit #(.OPCODE_W(6), .REG_W(5), .ALUOP_W(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_opcode     (id_opcode),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .branch_taken  (branch_taken),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .ifid_flush    (ifid_flush),
        .id_jump       (id_jump),
        .ex_reg_dst    (ex_reg_dst),
        .ex_alu_src    (ex_alu_src),
        .ex_ori        (ex_ori),
        .ex_alu_op     (ex_alu_op),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_branch    (mem_branch),
        .mem_bne       (mem_bne),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .illegal_op    (illegal_op)
`ifdef ILLEGAL_TRAP_EN
        ,
        .trap_flag     (trap_flag),
        .trap_opcode   (trap_opcode)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Word layout: [10]reg_dst [9]alu_src [8]ori [7:6]alu_op
    //              [5]mem_read [4]mem_write [3]branch [2]bne [1]reg_write [0]mem_to_reg
    logic [10:0] exp_q[$];
    logic        m_ex_mr;
    logic [4:0]  m_ex_rt;
    logic        m_trap;
    logic [5:0]  m_trap_op;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] ref_word(input logic [5:0] op);
        case (op)
            6'd0:    return 11'b1_0_0_10_0000_10;
            6'd8:    return 11'b0_1_0_00_0000_10;
            6'd13:   return 11'b0_1_1_11_0000_10;
            6'd35:   return 11'b0_1_0_00_1000_11;
            6'd43:   return 11'b0_1_0_00_0100_00;
            6'd4:    return 11'b0_0_0_01_0010_00;
            6'd5:    return 11'b0_0_0_01_0001_00;
            default: return 11'b0;
        endcase
    endfunction

    function automatic logic ref_legal(input logic [5:0] op);
        return op inside {6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd13, 6'd35, 6'd43};
    endfunction

    function automatic logic ref_reads_rt(input logic [5:0] op);
        return op inside {6'd0, 6'd43, 6'd4, 6'd5};
    endfunction

    task automatic check_stages();
        logic [10:0] w_wb, w_mem, w_ex;
        w_wb  = exp_q[0];
        w_mem = exp_q[1];
        w_ex  = exp_q[2];
        check_eq("ex_bundle",  {ex_reg_dst, ex_alu_src, ex_ori, ex_alu_op}, w_ex[10:6]);
        check_eq("mem_bundle", {mem_read, mem_write, mem_branch, mem_bne},  w_mem[5:2]);
        check_eq("wb_bundle",  {wb_reg_write, wb_mem_to_reg},               w_wb[1:0]);
`ifdef ILLEGAL_TRAP_EN
        check_eq("trap_flag",  trap_flag, m_trap);
        if (m_trap) check_eq("trap_opcode", trap_opcode, m_trap_op);
`endif
    endtask

    // Called just after a posedge; drives one ID-stage cycle and checks it.
    task automatic step(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic bt);
        logic       hz, exp_ill, rd_rs;
        logic [10:0] nw;
        id_opcode = op; id_rs = rs; id_rt = rt; branch_taken = bt;
        #1;
        rd_rs   = (op != 6'd2);
        hz      = m_ex_mr && (m_ex_rt != 5'd0) &&
                  ((rd_rs && rs == m_ex_rt) || (ref_reads_rt(op) && rt == m_ex_rt));
        exp_ill = !ref_legal(op) && !hz && !bt;
        check_eq("pc_write",   pc_write,   bt || !hz);
        check_eq("ifid_write", ifid_write, bt || !hz);
        check_eq("ifid_flush", ifid_flush, bt || (op == 6'd2 && !hz));
        check_eq("id_jump",    id_jump,    op == 6'd2);
        check_eq("illegal_op", illegal_op, exp_ill);
        $display("txn op=%0d rs=%0d rt=%0d bt=%0d hazard=%0d", op, rs, rt, bt, hz);
        @(posedge clk); #1;
        if (bt) exp_q[exp_q.size()-1] = exp_q[exp_q.size()-1] & 11'b111_1100_0000;
        nw = (bt || hz) ? 11'b0 : ref_word(op);
        exp_q.push_back(nw);
        m_ex_mr = nw[5];
        m_ex_rt = (bt || hz) ? 5'd0 : rt;
        if (exp_ill && !m_trap) begin
            m_trap    = 1'b1;
            m_trap_op = op;
        end
        void'(exp_q.pop_front());
        check_stages();
    endtask

    task automatic do_reset(input logic [5:0] op, input logic bt);
        rst = 1'b1; id_opcode = op; id_rs = 5'd7; id_rt = 5'd7; branch_taken = bt;
        #1;
        check_eq("rst_pc_write",   pc_write,   1'b1);
        check_eq("rst_ifid_write", ifid_write, 1'b1);
        check_eq("rst_ifid_flush", ifid_flush, 1'b0);
        check_eq("rst_illegal_op", illegal_op, 1'b0);
        check_eq("rst_id_jump",    id_jump,    1'b0);
        @(posedge clk); #1;
        exp_q.delete();
        repeat (3) exp_q.push_back(11'b0);
        m_ex_mr = 1'b0; m_ex_rt = 5'd0; m_trap = 1'b0; m_trap_op = 6'd0;
        check_stages();
`ifdef ILLEGAL_TRAP_EN
        check_eq("rst_trap_opcode", trap_opcode, 6'd0);
`endif
        $display("txn reset op=%0d bt=%0d", op, bt);
        rst = 1'b0;
    endtask

    initial begin
        m_trap = 1'b0; m_trap_op = 6'd0; m_ex_mr = 1'b0; m_ex_rt = 5'd0;
        do_reset(6'd63, 1'b1);
        do_reset(6'd2, 1'b0);

        // R-type then fill to see it in EX, MEM, WB
        step(6'd0, 5'd1, 5'd2, 1'b0);
        step(6'd8, 5'd0, 5'd0, 1'b0);
        step(6'd13, 5'd0, 5'd9, 1'b0);
        step(6'd43, 5'd3, 5'd4, 1'b0);
        // load-use: R reads rs=5 right after LW rt=5, then retries
        step(6'd35, 5'd1, 5'd5, 1'b0);
        step(6'd0, 5'd5, 5'd6, 1'b0);
        step(6'd0, 5'd5, 5'd6, 1'b0);
        // rt-use by SW, then BNE
        step(6'd35, 5'd1, 5'd9, 1'b0);
        step(6'd43, 5'd2, 5'd9, 1'b0);
        step(6'd43, 5'd2, 5'd9, 1'b0);
        step(6'd5, 5'd1, 5'd2, 1'b0);
        // no stall: ADDI does not read rt; $0 never stalls
        step(6'd35, 5'd1, 5'd5, 1'b0);
        step(6'd8, 5'd3, 5'd5, 1'b0);
        step(6'd35, 5'd1, 5'd0, 1'b0);
        step(6'd0, 5'd0, 5'd0, 1'b0);
        // taken branch in MEM while a load-use hazard is present
        step(6'd4, 5'd1, 5'd2, 1'b0);
        step(6'd35, 5'd1, 5'd7, 1'b0);
        step(6'd0, 5'd7, 5'd3, 1'b1);
        step(6'd0, 5'd7, 5'd3, 1'b0);
        // jump
        step(6'd2, 5'd0, 5'd0, 1'b0);
        step(6'd8, 5'd1, 5'd1, 1'b0);
        step(6'd0, 5'd0, 5'd0, 1'b0);
        step(6'd0, 5'd0, 5'd0, 1'b0);
        // illegal opcodes, including one held back by a stall
        step(6'd63, 5'd0, 5'd0, 1'b0);
        step(6'd63, 5'd0, 5'd0, 1'b0);
        step(6'd35, 5'd1, 5'd4, 1'b0);
        step(6'd50, 5'd4, 5'd0, 1'b0);
        step(6'd50, 5'd4, 5'd0, 1'b0);
        step(6'd0, 5'd0, 5'd0, 1'b0);
        // reset mid-stream discards in-flight bundles
        step(6'd35, 5'd1, 5'd8, 1'b0);
        step(6'd0, 5'd8, 5'd8, 1'b0);
        do_reset(6'd63, 1'b0);
        step(6'd13, 5'd2, 5'd3, 1'b0);
        repeat (3) step(6'd0, 5'd0, 5'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
